gpr_bank: RTL and testbench
===========================

# gpr_bank

Parametrised general-purpose register bank that supersedes the fixed 32×32, two-read-port register file in the CPU datapath. Width, depth and read-port count are configurable. A post-reset clear sequencer zeroes every entry, and optional write-to-read bypass forwards same-cycle writes. It sits between the decode stage (read addresses) and the writeback stage (write port).

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, address width; DEPTH = 2**ADDR_W entries
- NUM_RD, 2, number of read ports (1..4)
- ZERO_REG, 1, 1 = entry 0 hardwired to zero (writes ignored, reads 0)
- BYPASS, 1, 1 = read of the address being written this cycle returns WriteData

Ports:
- CLK  in  1  clock; all state updates on rising edge
- RST_N  in  1  reset, synchronous, active-low
- RegWrite  in  1  write enable
- WriteRegisterSelect  in  ADDR_W  write address
- WriteData  in  DATA_W  write data
- ReadRegister  in  NUM_RD*ADDR_W  packed read addresses; port k uses bits [k*ADDR_W +: ADDR_W]
- DataOut  out  NUM_RD*DATA_W  packed read data; port k uses bits [k*DATA_W +: DATA_W]
- Ready  out  1  high once the clear sequence has finished; writes are accepted only while high
- WriteDropped  out  1  registered pulse: a RegWrite was ignored in the previous cycle (Busy, or zero register)

## Operation
- FSM states: CLEAR, RUN.
- RST_N low at an edge: state ← CLEAR, clear pointer ← 0, Ready ← 0, WriteDropped ← 0. Array contents are not reset directly.
- CLEAR: at each edge with RST_N high, mem[ptr] ← 0 and ptr ← ptr+1. At the edge where ptr == DEPTH-1 is cleared, the FSM moves to RUN and Ready ← 1.
- RUN: if RegWrite is high and the write address is not zero-with-ZERO_REG, mem[addr] ← WriteData.
- RegWrite while in CLEAR: the write is ignored and WriteDropped pulses on the next cycle.
- RegWrite to entry 0 with ZERO_REG=1: the write is ignored and WriteDropped pulses on the next cycle.
- Reads are combinational from the array. Priority order:
  1. ZERO_REG and address 0 → 0.
  2. State CLEAR → 0.
  3. BYPASS, RegWrite, RUN and the read address equals the write address → WriteData.
  4. Otherwise → mem[addr].
- Multiple read ports may use the same address, with no restriction.
- RST_N asserted mid-clear or mid-RUN restarts the clear from entry 0. All prior contents are treated as lost.

## Timing
- Reset values: Ready=0, WriteDropped=0, DataOut=0 on every port (state is CLEAR).
- Clear latency: Ready rises after exactly DEPTH rising edges with RST_N high (32 for the default).
- Write latency: a write at edge n is visible on a non-bypassed read after edge n. With BYPASS=1 it is visible combinationally in the same cycle.
- WriteDropped is high for exactly one cycle, the cycle after the dropped request.
- No read latency; DataOut is combinational from the addresses and state.

## Configuration
- GPR_BANK_TRACE_EN defined: on every edge in RUN, a simulation-only $display prints a separator line and then all entries, four per line, formatted "R[a-b]" followed by hex values. If a write committed on that edge, one more line "R[addr] value" follows. The dump is synthesis-excluded.
- GPR_BANK_TRACE_EN undefined: no display code is compiled. Functional behaviour is identical.

## Structure
- Package gpr_pkg:
  - state enum gpr_state_t {CLEAR, RUN}
  - default localparams for DATA_W and ADDR_W
  - helper function for the packed read-port slice
- Sub-module gpr_clear_seq: owns the FSM, the clear pointer and Ready. It outputs a clear-write enable and address to the top, which muxes them onto the array write port ahead of RegWrite.
- The top contains the array, the NUM_RD read muxes generated by a generate loop, the bypass compare and WriteDropped.

## Test plan
- Reset and clear: hold RST_N low 3 cycles, release, then RegWrite=1 to addr 5 every cycle → Ready=0 and all reads 0 for 32 cycles; WriteDropped pulses each cycle; Ready=1 after edge 32.
- Basic write/read: in RUN, write 0xDEADBEEF to r7, then read r7 on both ports → 0xDEADBEEF from the next cycle. With BYPASS=1, the same cycle also returns 0xDEADBEEF.
- Zero register: write 0x12345678 to r0 → all reads of r0 return 0; WriteDropped=1 the following cycle.
- Bypass off: BYPASS=0, write 0xA5A5A5A5 to r3 while reading r3 (old value 0x1) → DataOut=0x1 that cycle, 0xA5A5A5A5 the next.
- Reset mid-operation: fill r1..r31 with nonzero data, assert RST_N for 1 cycle at clear pointer 10 and again in RUN → a fresh 32-cycle clear each time, and every entry reads 0 afterwards.
- Parametrisation: DATA_W=16, ADDR_W=3, NUM_RD=3, ZERO_REG=0 → Ready after 8 edges; r0 is writable; three ports independently return 0x0001, 0x0002, 0x0003 for r1, r2, r3.

Source files
------------

// File: rtl/gpr_pkg.sv
// Shared types and helpers for the parametrised register bank.
// No logic; no latency or backpressure of its own.
package gpr_pkg;

  typedef enum logic {CLEAR, RUN} gpr_state_t;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 5;

  // LSB of port k inside a packed multi-port bus of slice width w
  function automatic int rdLsb(input int port, input int width);
    return port * width;
  endfunction

endpackage

// File: rtl/gpr_clear_seq.sv
// Post-reset clear sequencer: walks every entry once, then raises Ready (DEPTH edges).
// No backpressure; the write port is owned by this block until Ready.
import gpr_pkg::*;

module gpr_clear_seq #(
  parameter int ADDR_W = DEF_ADDR_W
) (
  input  logic              CLK,
  input  logic              RST_N,
  output gpr_state_t        state,
  output logic              Ready,
  output logic              clrEn,
  output logic [ADDR_W-1:0] clrAddr
);

  logic [ADDR_W-1:0] ptr;

  always_ff @(posedge CLK) begin
    if (!RST_N) begin
      state <= CLEAR;
      ptr   <= '0;
      Ready <= 1'b0;
    end else if (state == CLEAR) begin
      ptr <= ptr + 1'b1;
      if (ptr == '1) begin
        state <= RUN;
        Ready <= 1'b1;
      end
    end
  end

  // Held off during reset so the array is never touched while RST_N is low
  assign clrEn   = RST_N && (state == CLEAR);
  assign clrAddr = ptr;

endmodule

// File: rtl/gpr_bank.sv
// Parametrised GPR bank: combinational reads, 1-edge writes, optional bypass; writes dropped until Ready.
// Optional GPR_BANK_TRACE_EN compiles a simulation-only register dump on every RUN edge.
import gpr_pkg::*;

module gpr_bank #(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int NUM_RD   = 2,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                     CLK,
  input  logic                     RST_N,
  input  logic                     RegWrite,
  input  logic [ADDR_W-1:0]        WriteRegisterSelect,
  input  logic [DATA_W-1:0]        WriteData,
  input  logic [NUM_RD*ADDR_W-1:0] ReadRegister,
  output logic [NUM_RD*DATA_W-1:0] DataOut,
  output logic                     Ready,
  output logic                     WriteDropped
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem [DEPTH];

  gpr_state_t        state;
  logic              clrEn;
  logic [ADDR_W-1:0] clrAddr;

  gpr_clear_seq #(.ADDR_W(ADDR_W)) uClearSeq (
    .CLK     (CLK),
    .RST_N   (RST_N),
    .state   (state),
    .Ready   (Ready),
    .clrEn   (clrEn),
    .clrAddr (clrAddr)
  );

  logic              wrZero;
  logic              wrCommit;
  logic              memWe;
  logic [ADDR_W-1:0] memAddr;
  logic [DATA_W-1:0] memData;

  assign wrZero   = (ZERO_REG != 0) && (WriteRegisterSelect == '0);
  assign wrCommit = RegWrite && (state == RUN) && !wrZero;

  // Clear and functional writes are mutually exclusive by state; clear wins the port
  assign memWe   = clrEn || (RST_N && wrCommit);
  assign memAddr = clrEn ? clrAddr : WriteRegisterSelect;
  assign memData = clrEn ? '0 : WriteData;

  always_ff @(posedge CLK) begin
    if (memWe) mem[memAddr] <= memData;
  end

  always_ff @(posedge CLK) begin
    if (!RST_N) WriteDropped <= 1'b0;
    else        WriteDropped <= RegWrite && ((state == CLEAR) || wrZero);
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : gRd
    logic [ADDR_W-1:0] ra;
    logic [DATA_W-1:0] rd;

    assign ra = ReadRegister[rdLsb(k, ADDR_W) +: ADDR_W];

    always_comb begin
      rd = mem[ra];
      if ((ZERO_REG != 0) && (ra == '0))                                rd = '0;
      else if (state == CLEAR)                                          rd = '0;
      else if ((BYPASS != 0) && RegWrite && (ra == WriteRegisterSelect)) rd = WriteData;
    end

    assign DataOut[rdLsb(k, DATA_W) +: DATA_W] = rd;
  end

`ifdef GPR_BANK_TRACE_EN
`ifndef SYNTHESIS
  always @(posedge CLK) begin
    if (RST_N && (state == RUN)) begin
      $display("----------------------------------------");
      for (int a = 0; a < DEPTH; a += 4) begin
        $write("R[%0d-%0d]", a, ((a + 3) < DEPTH) ? (a + 3) : (DEPTH - 1));
        for (int b = a; (b < a + 4) && (b < DEPTH); b++) $write(" %h", mem[b]);
        $write("\n");
      end
      if (wrCommit) $display("R[%0d] %h", WriteRegisterSelect, WriteData);
    end
  end
`endif
`endif

endmodule

// File: tb/tb_gpr_bank.sv
// Randomised + directed bench for gpr_bank: default build and a small no-zero/no-bypass build,
// both checked every cycle against a behavioural model of the register bank.
module tb_gpr_bank;

  logic CLK = 1'b0;
  always #5 CLK = ~CLK;

  logic RST_N;

  logic        aWe;
  logic [4:0]  aWa;
  logic [31:0] aWd;
  logic [9:0]  aRa;
  logic [63:0] aDo;
  logic        aReady, aDrop;

  logic        bWe;
  logic [2:0]  bWa;
  logic [15:0] bWd;
  logic [8:0]  bRa;
  logic [47:0] bDo;
  logic        bReady, bDrop;

  gpr_bank dutA (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .RegWrite            (aWe),
    .WriteRegisterSelect (aWa),
    .WriteData           (aWd),
    .ReadRegister        (aRa),
    .DataOut             (aDo),
    .Ready               (aReady),
    .WriteDropped        (aDrop)
  );

  gpr_bank #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .ZERO_REG(0), .BYPASS(0)) dutB (
    .CLK                 (CLK),
    .RST_N               (RST_N),
    .RegWrite            (bWe),
    .WriteRegisterSelect (bWa),
    .WriteData           (bWd),
    .ReadRegister        (bRa),
    .DataOut             (bDo),
    .Ready               (bReady),
    .WriteDropped        (bDrop)
  );

  int vectors = 0;
  int miscompares = 0;

  // Reference state: contents, edges spent clearing, ready flag, pending drop pulse
  logic [31:0] mA [32];
  int          cntA;
  bit          rdyA, dropA;
  logic [15:0] mB [8];
  int          cntB;
  bit          rdyB, dropB;

  function automatic logic [31:0] expA(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    if (!rdyA) return 32'd0;
    if (aWe && (a == aWa)) return aWd;
    return mA[a];
  endfunction

  function automatic logic [15:0] expB(input logic [2:0] a);
    if (!rdyB) return 16'd0;
    return mB[a];
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic checkAll();
    chk("A.Ready", {31'd0, aReady}, {31'd0, rdyA});
    chk("A.WriteDropped", {31'd0, aDrop}, {31'd0, dropA});
    for (int k = 0; k < 2; k++)
      chk($sformatf("A.DataOut%0d", k), aDo[k*32 +: 32], expA(aRa[k*5 +: 5]));
    chk("B.Ready", {31'd0, bReady}, {31'd0, rdyB});
    chk("B.WriteDropped", {31'd0, bDrop}, {31'd0, dropB});
    for (int k = 0; k < 3; k++)
      chk($sformatf("B.DataOut%0d", k), {16'd0, bDo[k*16 +: 16]}, {16'd0, expB(bRa[k*3 +: 3])});
  endtask

  task automatic update();
    if (!RST_N) begin
      cntA = 0; rdyA = 0; dropA = 0;
      cntB = 0; rdyB = 0; dropB = 0;
    end else begin
      if (!rdyA) begin
        dropA = aWe;
        cntA++;
        if (cntA == 32) begin
          rdyA = 1;
          foreach (mA[i]) mA[i] = 32'd0;
        end
      end else begin
        dropA = aWe && (aWa == 5'd0);
        if (aWe && (aWa != 5'd0)) mA[aWa] = aWd;
      end
      if (!rdyB) begin
        dropB = bWe;
        cntB++;
        if (cntB == 8) begin
          rdyB = 1;
          foreach (mB[i]) mB[i] = 16'd0;
        end
      end else begin
        dropB = 0;
        if (bWe) mB[bWa] = bWd;
      end
    end
  endtask

  task automatic cycle();
    @(negedge CLK);
    checkAll();
    @(posedge CLK);
    update();
    #1;
  endtask

  task automatic randA();
    aWe = 1'($urandom_range(0, 1));
    aWa = 5'($urandom);
    aWd = $urandom;
    aRa = 10'($urandom);
  endtask

  task automatic randB();
    bWe = 1'($urandom_range(0, 1));
    bWa = 3'($urandom);
    bWd = 16'($urandom);
    bRa = 9'($urandom);
  endtask

  initial begin
    RST_N = 1'b0;
    randA();
    randB();
    @(posedge CLK);
    update();
    #1;
    repeat (2) begin randA(); randB(); cycle(); end

    // Clear window: persistent write to r5 must be dropped every cycle
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++) begin
      aWe = 1'b1; aWa = 5'd5; aWd = $urandom; aRa = 10'($urandom);
      randB();
      cycle();
    end

    // Write/read r7 on both ports, bypassed then from the array
    bWe = 1'b0;
    aWe = 1'b1; aWa = 5'd7; aWd = 32'hDEADBEEF; aRa = {5'd7, 5'd7};
    cycle();
    aWe = 1'b0;
    cycle();

    // Zero register write is dropped
    aWe = 1'b1; aWa = 5'd0; aWd = 32'h12345678; aRa = {5'd0, 5'd0};
    cycle();
    aWe = 1'b0;
    cycle();

    // No bypass on B: old value during the write cycle, new value after
    bWe = 1'b1; bWa = 3'd3; bWd = 16'h0001; bRa = {3'd3, 3'd3, 3'd3};
    cycle();
    bWd = 16'hA5A5;
    cycle();
    bWe = 1'b0;
    cycle();

    for (int i = 0; i < 400; i++) begin randA(); randB(); cycle(); end

    // Fill, then reset mid-clear (pointer 10) and restart
    for (int i = 1; i < 32; i++) begin
      aWe = 1'b1; aWa = 5'(i); aWd = (i * 32'h01010101) | 32'h1; aRa = 10'($urandom);
      randB();
      cycle();
    end
    RST_N = 1'b0; randA(); randB(); cycle();
    RST_N = 1'b1;
    for (int i = 0; i < 10; i++) begin randA(); randB(); cycle(); end
    RST_N = 1'b0; randA(); randB(); cycle();
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++) begin randA(); randB(); cycle(); end
    aWe = 1'b0; bWe = 1'b0;
    for (int i = 0; i < 32; i++) begin
      aRa = {5'(i), 5'(31 - i)};
      bRa = {3'(i), 3'(i + 1), 3'(i + 2)};
      cycle();
    end

    // Reset while running
    for (int i = 0; i < 40; i++) begin randA(); aWe = 1'b1; randB(); cycle(); end
    RST_N = 1'b0; randA(); randB(); cycle();
    RST_N = 1'b1;
    for (int i = 0; i < 32; i++) begin randA(); randB(); cycle(); end
    aWe = 1'b0; bWe = 1'b0;
    for (int i = 0; i < 32; i++) begin
      aRa = {5'(31 - i), 5'(i)};
      bRa = {3'(i), 3'(i), 3'(i + 5)};
      cycle();
    end

    // Small build: independent ports and a writable r0
    bWe = 1'b1;
    bWa = 3'd1; bWd = 16'h0001; cycle();
    bWa = 3'd2; bWd = 16'h0002; cycle();
    bWa = 3'd3; bWd = 16'h0003; cycle();
    bWa = 3'd0; bWd = 16'h0BAD; cycle();
    bWe = 1'b0;
    bRa = {3'd3, 3'd2, 3'd1}; cycle();
    bRa = {3'd0, 3'd1, 3'd0}; cycle();

    for (int i = 0; i < 200; i++) begin randA(); randB(); cycle(); end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
